// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: front-end controller for the 8-bit ALU.
// A command is entered in three button presses: opcode, then operand A,
// then operand B. The block drives the registered opcode and operands into
// the ALU. For the sequential multiply (opcode 12) it pulses mul_start and
// waits MUL_CYCLES cycles. It then captures the 16-bit ALU result into a
// held register and reports valid, busy and illegal-opcode status.
module alu_cmd_sequencer #(
  parameter int MUL_CYCLES = 8,   // cycles from mul_start to a stable product, >= 1
  parameter int OPCODE_MAX = 12   // highest legal opcode
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enter,
  input  logic        abort,
  input  logic [7:0]  switch,
  input  logic [15:0] alu_result,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        mul_start,
  output logic [15:0] result,
  output logic        result_valid,
  output logic        busy,
  output logic        err_illegal,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    EXEC     = 3'd3,
    MUL_WAIT = 3'd4
  } state_e;

  // The down-counter only ever holds MUL_CYCLES-1 .. 0.
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  // One extra bit so that an OPCODE_MAX of 15 or more makes every opcode legal.
  localparam logic [4:0] OP_MAX = 5'(OPCODE_MAX);
  localparam logic [3:0] MUL_OP = 4'd12;

  state_e            state_q;
  logic              enter_q;
  logic [3:0]        opcode_q;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [15:0]       result_q;
  logic              valid_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              press_s;
  logic              legal_s;
  logic              is_mul_s;

  // Rising edge of the (already synchronised) button and opcode legality decode.
  always_comb begin
    press_s  = enter & ~enter_q;
    legal_s  = ({1'b0, switch[3:0]} <= OP_MAX);
    is_mul_s = (opcode_q == MUL_OP);
  end

  // Command FSM: step through entry, execution and capture; all held outputs live here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      enter_q  <= 1'b0;
      opcode_q <= 4'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      result_q <= 16'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= CNT_ZERO;
    end else begin
      // Registered every cycle so that holding the button yields one action only.
      enter_q <= enter;
      case (state_q)
        IDLE: begin
          // abort is meaningless here; a press is still honoured.
          if (press_s) begin
            valid_q <= 1'b0;
            if (legal_s) begin
              err_q    <= 1'b0;
              opcode_q <= switch[3:0];
              state_q  <= GET_A;
            end else begin
              // Illegal opcode: flag it and keep the previous opcode on the ALU.
              err_q <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (press_s) begin
            a_q     <= switch;
            state_q <= GET_B;
          end
        end
        GET_B: begin
          if (abort) begin
            state_q <= IDLE;
          end else if (press_s) begin
            b_q     <= switch;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // The operands have been on the ALU for one full cycle at this point.
          if (abort) begin
            state_q <= IDLE;
          end else if (is_mul_s) begin
            cnt_q   <= CNT_LOAD;
            state_q <= MUL_WAIT;
          end else begin
            result_q <= alu_result;
            valid_q  <= 1'b1;
            state_q  <= IDLE;
          end
        end
        MUL_WAIT: begin
          // Capture on the edge after the counter reaches zero: MUL_CYCLES after EXEC.
          if (abort) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_ZERO) begin
            result_q <= alu_result;
            valid_q  <= 1'b1;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Status decode from the state register; mul_start is withdrawn when aborted in EXEC.
  always_comb begin
    busy      = (state_q != IDLE);
    mul_start = (state_q == EXEC) && is_mul_s && !abort;
    state_dbg = state_q;
  end

  // Drive the held registers straight onto the output ports.
  always_comb begin
    alu_opcode   = opcode_q;
    alu_a        = a_q;
    alu_b        = b_q;
    result       = result_q;
    result_valid = valid_q;
    err_illegal  = err_q;
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: directed command sequences. A spec-level model
// predicts every output each cycle, and literal expectations pin key values.
module tb_alu_cmd_sequencer;

  localparam int MUL_CYCLES = 8;
  localparam int OPCODE_MAX = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enter = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  sw = 8'd0;
  logic [15:0] alu_result;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        mul_start;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        err_illegal;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_fail = 0;
  int n_ms = 0;

  alu_cmd_sequencer #(.MUL_CYCLES(MUL_CYCLES), .OPCODE_MAX(OPCODE_MAX)) dut (
    .clk(clk), .rst(rst), .enter(enter), .abort(abort), .switch(sw),
    .alu_result(alu_result), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .mul_start(mul_start), .result(result), .result_valid(result_valid),
    .busy(busy), .err_illegal(err_illegal), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour.
  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd1:    alu_fn = {8'h00, a} + {8'h00, b};
      4'd2:    alu_fn = {8'h00, a} - {8'h00, b};
      4'd3:    alu_fn = {8'h00, a & b};
      4'd4:    alu_fn = {8'h00, a | b};
      4'd5:    alu_fn = {8'h00, a ^ b};
      4'd6:    alu_fn = {a, b};
      4'd12:   alu_fn = 16'(a) * 16'(b);
      default: alu_fn = {8'h00, ~a};
    endcase
  endfunction

  // ALU stand-in: the multiply product is garbage until MUL_CYCLES edges after mul_start.
  logic mul_seen = 1'b0;
  int   mul_edges = 0;
  always @(negedge clk) mul_seen <= mul_start;
  always @(posedge clk or posedge rst) begin
    if (rst) mul_edges <= 0;
    else if (mul_seen) mul_edges <= 1;
    else if (mul_edges < 1000) mul_edges <= mul_edges + 1;
  end
  assign alu_result = (alu_opcode == 4'd12)
                      ? ((mul_edges >= MUL_CYCLES) ? alu_fn(alu_opcode, alu_a, alu_b)
                                                   : (16'hBAD0 ^ 16'(mul_edges)))
                      : alu_fn(alu_opcode, alu_a, alu_b);

  // Behavioural model: phase of command entry plus an absolute capture deadline.
  int          m_phase = 0;
  logic [3:0]  m_op = 4'd0;
  logic [7:0]  m_a = 8'd0;
  logic [7:0]  m_b = 8'd0;
  logic [15:0] m_result = 16'd0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic        m_enter_prev = 1'b0;
  int          cyc_n = 0;
  int          m_due = 0;
  logic        m_press;
  assign m_press = enter && !m_enter_prev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0; m_op <= 4'd0; m_a <= 8'd0; m_b <= 8'd0;
      m_result <= 16'd0; m_valid <= 1'b0; m_err <= 1'b0; m_enter_prev <= 1'b0;
    end else begin
      cyc_n <= cyc_n + 1;
      m_enter_prev <= enter;
      if (m_phase == 0) begin
        if (m_press) begin
          m_valid <= 1'b0;
          if (int'(sw[3:0]) > OPCODE_MAX) m_err <= 1'b1;
          else begin m_err <= 1'b0; m_op <= sw[3:0]; m_phase <= 1; end
        end
      end else if (abort) begin
        m_phase <= 0;
      end else if (m_phase == 1) begin
        if (m_press) begin m_a <= sw; m_phase <= 2; end
      end else if (m_phase == 2) begin
        if (m_press) begin m_b <= sw; m_phase <= 3; end
      end else if (m_phase == 3) begin
        if (m_op == 4'd12) begin
          m_phase <= 4;
          m_due <= cyc_n + 1 + MUL_CYCLES;
        end else begin
          m_result <= alu_fn(m_op, m_a, m_b); m_valid <= 1'b1; m_phase <= 0;
        end
      end else if (cyc_n + 1 == m_due) begin
        m_result <= alu_fn(m_op, m_a, m_b); m_valid <= 1'b1; m_phase <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state_dbg", 16'(state_dbg), 16'(m_phase));
    chk("busy", 16'(busy), 16'(m_phase != 0));
    chk("mul_start", 16'(mul_start), 16'((m_phase == 3) && (m_op == 4'd12) && !abort));
    chk("alu_opcode", 16'(alu_opcode), 16'(m_op));
    chk("alu_a", 16'(alu_a), 16'(m_a));
    chk("alu_b", 16'(alu_b), 16'(m_b));
    chk("result", result, m_result);
    chk("result_valid", 16'(result_valid), 16'(m_valid));
    chk("err_illegal", 16'(err_illegal), 16'(m_err));
    if (mul_start) n_ms++;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic press(input logic [7:0] v);
    sw = v; enter = 1'b1; step(1);
    enter = 1'b0; step(1);
  endtask

  initial begin
    fork
      forever begin @(negedge clk); compare_all(); end
    join_none
    #1 rst = 1'b1;
    step(2);
    chk("rst_state", 16'(state_dbg), 16'd0);
    chk("rst_result", result, 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    step(1);

    // Add 5 + 3
    press(8'h01);
    chk("add_busy", 16'(busy), 16'd1);
    press(8'h05); press(8'h03);
    chk("add_result", result, 16'h0008);
    chk("add_valid", 16'(result_valid), 16'd1);
    chk("add_state", 16'(state_dbg), 16'd0);
    chk("add_no_mulstart", 16'(n_ms), 16'd0);

    // Multiply 0x0F * 0x0F, with ignored presses during MUL_WAIT
    press(8'h0C); press(8'h0F);
    sw = 8'h0F; enter = 1'b1; step(1);          // edge E
    enter = 1'b0;
    chk("mul_start_E", 16'(mul_start), 16'd1);
    step(1);                                    // edge E+1
    chk("mul_start_E1", 16'(mul_start), 16'd0);
    chk("mul_wait_state", 16'(state_dbg), 16'd4);
    press(8'h55);                               // edge E+3
    chk("mul_hold_state", 16'(state_dbg), 16'd4);
    chk("mul_hold_a", 16'(alu_a), 16'h000F);
    step(5);                                    // edge E+8
    chk("mul_not_early", 16'(result_valid), 16'd0);
    step(1);                                    // edge E+9
    chk("mul_result", result, 16'h00E1);
    chk("mul_valid", 16'(result_valid), 16'd1);
    chk("mul_pulse_count", 16'(n_ms), 16'd1);

    // Illegal opcode then legal one
    press(8'h0E);
    chk("ill_err", 16'(err_illegal), 16'd1);
    chk("ill_state", 16'(state_dbg), 16'd0);
    chk("ill_opcode", 16'(alu_opcode), 16'd12);
    press(8'h06);
    chk("legal_err", 16'(err_illegal), 16'd0);
    chk("legal_state", 16'(state_dbg), 16'd1);

    // Held button in GET_A
    sw = 8'h21; enter = 1'b1; step(1);
    sw = 8'h77; step(19);
    enter = 1'b0; step(1);
    chk("held_a", 16'(alu_a), 16'h0021);
    chk("held_state", 16'(state_dbg), 16'd2);
    press(8'h02);
    chk("cat_result", result, 16'h2102);

    // abort together with a press in GET_B
    press(8'h04); press(8'h10);
    sw = 8'h99; enter = 1'b1; abort = 1'b1; step(1);
    abort = 1'b0; enter = 1'b0; step(1);
    chk("abortb_state", 16'(state_dbg), 16'd0);
    chk("abortb_b", 16'(alu_b), 16'h0002);

    // abort in MUL_WAIT
    press(8'h0C); press(8'h03); press(8'h04);   // ends just after E+1
    step(3);
    abort = 1'b1; step(1);
    abort = 1'b0;
    chk("abortm_state", 16'(state_dbg), 16'd0);
    chk("abortm_valid", 16'(result_valid), 16'd0);
    chk("abortm_result", result, 16'h2102);
    step(10);
    chk("abortm_late", 16'(result_valid), 16'd0);
    chk("abortm_pulses", 16'(n_ms), 16'd2);

    // abort in IDLE does not block a press
    sw = 8'h01; enter = 1'b1; abort = 1'b1; step(1);
    abort = 1'b0; enter = 1'b0; step(1);
    chk("idle_abort_state", 16'(state_dbg), 16'd1);
    chk("idle_abort_op", 16'(alu_opcode), 16'd1);

    // Asynchronous reset mid-GET_B, then a full command
    press(8'h40);
    #1 rst = 1'b1;
    #1;
    chk("arst_state", 16'(state_dbg), 16'd0);
    chk("arst_a", 16'(alu_a), 16'd0);
    chk("arst_op", 16'(alu_opcode), 16'd0);
    chk("arst_result", result, 16'd0);
    chk("arst_busy", 16'(busy), 16'd0);
    step(1);
    rst = 1'b0;
    step(1);
    press(8'h02); press(8'h09); press(8'h04);
    chk("post_rst_result", result, 16'h0005);
    chk("post_rst_valid", 16'(result_valid), 16'd1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
